ru_write_arbiter: RTL
=====================

RU_WRITE_ARBITER -- requirements
Module: ru_write_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of the register unit.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 SHALL have port req0_rd  input  AW  requester 0 destination register.
REQ-007 SHALL have port req0_data  input  XLEN  requester 0 write data.
REQ-008 SHALL have port req0_ready  output  1  requester 0 granted this cycle.
REQ-009 SHALL have ports req1_valid, req1_rd, req1_data, req1_ready with the same directions, widths and meanings for requester 1 (load writeback).
REQ-010 SHALL have port RUWr  output  1  write enable to the register unit.
REQ-011 SHALL have port rd  output  AW  write address to the register unit.
REQ-012 SHALL have port DataWr  output  XLEN  write data to the register unit.
REQ-013 SHALL have port pending  output  2^AW  one-hot mask of the register currently held in the output stage.

Function
REQ-014 SHALL complete a transfer when reqN_valid and reqN_ready are both 1 at a rising edge.
REQ-015 SHALL drive reqN_ready combinationally from the valids and the arbitration state, never from reqN_data or reqN_rd.
REQ-016 SHALL assert at most one ready per cycle, and SHALL never assert a ready whose valid is 0.
REQ-017 SHALL grant the sole requester immediately when only one valid is high.
REQ-018 SHALL resolve contention, with both valids high, per REQ-029/REQ-030.
REQ-019 SHALL require a requester to hold valid, rd and data stable until its transfer; a bench violation is undefined behaviour.
REQ-020 SHALL load rd and DataWr from the winner on the transfer edge and assert RUWr for exactly the following cycle, giving 1-cycle latency from transfer to RUWr.
REQ-021 SHALL accept a transfer with rd = 0 (ready asserted) but keep RUWr = 0 for it; x0 is never written.
REQ-022 SHALL set pending to 1 << rd while RUWr = 1, and to 0 otherwise.
REQ-023 SHALL clear RUWr to 0 in any cycle following an edge with no transfer; rd and DataWr SHALL hold their last values.
REQ-024 SHALL sustain back-to-back transfers, one per cycle, with no bubble.
REQ-025 SHALL, when both requesters target the same rd in the same cycle, write the winner first and the loser on the next grant, so the loser's data is the final value.

Reset
REQ-026 SHALL, while rst = 1, force RUWr = 0, rd = 0, DataWr = 0, pending = 0 and both readys to 0, independent of clk.
REQ-027 SHALL set the arbitration state on reset so that requester 0 wins the first contention.
REQ-028 SHALL discard an in-flight write on reset assertion (RUWr drops immediately); the first grant after release SHALL occur on the first rising edge with rst = 0.

Configuration
REQ-029 SHALL, with RU_WR_RR_EN defined, use round-robin arbitration: on contention, grant the requester not granted by the most recent transfer, with the last-grant pointer updating only on transfers.
REQ-030 SHALL, without RU_WR_RR_EN, use fixed priority: requester 0 always wins contention, and no pointer state is implemented.

Structure
REQ-031 SHALL take XLEN, AW, the X0 address constant and the requester-id enum (REQ_ALU, REQ_LOAD) from shared package ru_pkg.
REQ-032 SHALL implement grant selection in sub-module ru_arb2 (two valids in, one-hot grant out, pointer inside under RU_WR_RR_EN); the datapath register stays in ru_write_arbiter.

Verification
REQ-033 SHALL check: req0 only, rd = 1, data = 0x00000008 -> req0_ready = 1 same cycle; next cycle RUWr = 1, rd = 1, DataWr = 0x8, pending = 0x00000002.
REQ-034 SHALL check: both valid for 4 cycles (req0 rd = 2 data = 0xA; req1 rd = 3 data = 0xFFFFFFFE) with RU_WR_RR_EN -> grants 0,1,0,1; without it -> grants 0,0,0,0 and req1_ready stays 0.
REQ-035 SHALL check: req1 rd = 0, data = 0x1 -> req1_ready = 1, next cycle RUWr = 0 and pending = 0.
REQ-036 SHALL check: same-cycle contention on rd = 5 (req0 data 0x11, req1 data 0x22) -> RUWr pulses twice on consecutive cycles, the last with DataWr = 0x22.
REQ-037 SHALL check: rst asserted mid-cycle while RUWr = 1 -> RUWr, rd, DataWr and pending are 0 before the next edge; after release, req0 wins the first contention.

Source files
------------

// File: rtl/ru_pkg.sv
// Shared constants and requester ids for the register-unit write arbiter.
package ru_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] X0 = '0;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

endpackage

// File: rtl/ru_arb2.sv
// Two-requester grant selection. RU_WR_RR_EN selects round-robin with a
// last-grant pointer; otherwise requester 0 has fixed priority and no state.
module ru_arb2
    import ru_pkg::*;
(
`ifdef RU_WR_RR_EN
    input  logic       clk,
`endif
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef RU_WR_RR_EN
    req_id_e last_q;
    req_id_e last_d;

    // Pointer starts at REQ_LOAD so REQ_ALU wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= REQ_LOAD;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (grant[0])      last_d = REQ_ALU;
        else if (grant[1]) last_d = REQ_LOAD;
    end

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (valid == 2'b11) grant = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
            else                grant = valid;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (!rst) grant = valid[0] ? 2'b01 : valid;
    end
`endif

endmodule

// File: rtl/ru_write_arbiter.sv
// Arbitrates ALU and load writebacks into a single register-unit write port.
// Arbitration policy is selected by RU_WR_RR_EN (see ru_arb2).
module ru_write_arbiter #(
    parameter int XLEN = ru_pkg::XLEN,
    parameter int AW   = ru_pkg::AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    output logic              RUWr,
    output logic [AW-1:0]     rd,
    output logic [XLEN-1:0]   DataWr,
    output logic [2**AW-1:0]  pending
);
    import ru_pkg::*;

    logic [1:0]      grant;
    logic            ruwr_q, ruwr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    ru_arb2 u_arb (
`ifdef RU_WR_RR_EN
        .clk   (clk),
`endif
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ruwr_d = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant[1]) begin
            rd_d   = req1_rd;
            data_d = req1_data;
            ruwr_d = (req1_rd != AW'(X0));
        end else if (grant[0]) begin
            rd_d   = req0_rd;
            data_d = req0_data;
            ruwr_d = (req0_rd != AW'(X0));
        end
    end

    // NOTE: state uses non-blocking assignments; async reset drops RUWr immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ruwr_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            ruwr_q <= ruwr_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign RUWr   = ruwr_q;
    assign rd     = rd_q;
    assign DataWr = data_q;

    always_comb begin
        pending = '0;
        if (ruwr_q) pending[rd_q] = 1'b1;
    end

endmodule
